// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of STAGES valid/data register stages with
// bubble-collapsing backpressure, per-stage kill and a whole-chain flush.
// The ready chain is combinational from out_ready_i back to in_ready_o, so
// a stalled output only blocks the stages behind it that actually hold live
// entries; empty or killed stages keep loading.
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 3,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    input  logic [STAGES-1:0] kill_i,
    output logic [OCC_W-1:0]  occupancy_o
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];

    logic [STAGES-1:0] live;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] src_v;
    logic [DATA_W-1:0] src_d [STAGES];
    logic [OCC_W-1:0]  occ;

    // Live bits and the ready chain, walked from the output back to stage 0
    always_comb begin
        live = v_q & ~kill_i;
        rdy = '0;
        rdy[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~live[k] | rdy[k+1];
        end
    end

    // Entry offered to each stage: stage 0 from the port, stage k from stage k-1
    always_comb begin
        src_v = '0;
        src_v[0] = in_valid_i & ~flush_i;
        src_d[0] = in_data_i;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = live[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    // Next state: flush empties the chain, loading stages take the offered entry, stalled stages hold
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            d_d[k] = d_q[k];
            if (flush_i) begin
                v_d[k] = 1'b0;
            end else if (rdy[k]) begin
                v_d[k] = src_v[k];
                // Data only moves with a live entry so idle stages never sample junk
                if (src_v[k]) begin
                    d_d[k] = src_d[k];
                end
            end
        end
    end

    // Stage registers, cleared asynchronously by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    // Occupancy counts registered valid bits only, ignoring this cycle's kill/flush
    always_comb begin
        occ = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(v_q[k]);
        end
    end

    assign in_ready_o  = rdy[0] & ~flush_i;
    assign out_valid_o = live[STAGES-1] & ~flush_i;
    assign out_data_o  = d_q[STAGES-1];
    assign occupancy_o = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (STAGES=3, DATA_W=32): directed scenarios with
// literal expectations, then randomized traffic. A queue of in-flight entries
// tagged with their stage position serves as the reference; each cycle the
// oldest entry exits if possible and every other entry advances one position
// unless the slot ahead stays occupied.
module tb_pipe_stage_chain;

    localparam int S  = 3;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [S-1:0]  kill_i = '0;
    logic [1:0]    occupancy_o;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        int          pos;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t tmp[$];
    int   bound;
    int   np;
    logic exp_ov;
    logic exp_ir;

    pipe_stage_chain #(.DATA_W(DW), .STAGES(S)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .flush_i     (flush_i),
        .kill_i      (kill_i),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: compare the current outputs, then advance to the next edge
    always @(negedge clk_i) begin
        if (rst_i) begin
            mq.delete();
            check("rst_out_valid", 64'(out_valid_o), 64'(0));
            check("rst_out_data", 64'(out_data_o), 64'(0));
            check("rst_occupancy", 64'(occupancy_o), 64'(0));
            check("rst_in_ready", 64'(in_ready_o), 64'(!flush_i));
        end else begin
            tmp.delete();
            foreach (mq[i]) begin
                if (!kill_i[mq[i].pos]) tmp.push_back(mq[i]);
            end
            exp_ov = !flush_i && tmp.size() > 0 && tmp[0].pos == S - 1;
            check("occupancy", 64'(occupancy_o), 64'(mq.size()));
            check("out_valid", 64'(out_valid_o), 64'(exp_ov));
            if (exp_ov) check("out_data", 64'(out_data_o), 64'(tmp[0].data));
            if (flush_i) begin
                exp_ir = 1'b0;
                tmp.delete();
            end else begin
                if (exp_ov && out_ready_i) void'(tmp.pop_front());
                bound = S - 1;
                foreach (tmp[i]) begin
                    np = (tmp[i].pos + 1 <= bound) ? tmp[i].pos + 1 : tmp[i].pos;
                    tmp[i].pos = np;
                    bound = np - 1;
                end
                exp_ir = (bound >= 0);
                if (in_valid_i && exp_ir) tmp.push_back('{pos: 0, data: in_data_i});
            end
            check("in_ready", 64'(in_ready_o), 64'(exp_ir));
            mq = tmp;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic ordy,
                          input logic fl, input logic [S-1:0] kl);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        kill_i      = kl;
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0);
        rst_i = 1'b1;
        #1;
        check("lit_rst_occ", 64'(occupancy_o), 64'(0));
        check("lit_rst_ov", 64'(out_valid_o), 64'(0));
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();

        // Latency and throughput
        set_in(1'b1, 32'hA1, 1'b1, 1'b0, '0); tick();
        set_in(1'b1, 32'hA2, 1'b1, 1'b0, '0); tick();
        set_in(1'b1, 32'hA3, 1'b1, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0); #1;
        check("lat_ov1", 64'(out_valid_o), 64'(1));
        check("lat_od1", 64'(out_data_o), 64'(32'hA1));
        check("lat_occ_peak", 64'(occupancy_o), 64'(3));
        tick(); #1;
        check("lat_od2", 64'(out_data_o), 64'(32'hA2));
        check("lat_occ2", 64'(occupancy_o), 64'(2));
        tick(); #1;
        check("lat_od3", 64'(out_data_o), 64'(32'hA3));
        tick(); #1;
        check("lat_empty_ov", 64'(out_valid_o), 64'(0));
        check("lat_empty_occ", 64'(occupancy_o), 64'(0));

        // Backpressure with simultaneous enqueue/dequeue when full
        do_reset();
        set_in(1'b1, 32'h10, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h11, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h12, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0); #1;
        check("bp_in_ready", 64'(in_ready_o), 64'(0));
        check("bp_occ", 64'(occupancy_o), 64'(3));
        check("bp_od", 64'(out_data_o), 64'(32'h10));
        tick(); #1;
        check("bp_od_stable", 64'(out_data_o), 64'(32'h10));
        set_in(1'b1, 32'h13, 1'b1, 1'b0, '0); #1;
        check("bp_in_ready_full", 64'(in_ready_o), 64'(1));
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0); #1;
        check("bp_occ_after", 64'(occupancy_o), 64'(3));
        check("bp_od_after", 64'(out_data_o), 64'(32'h11));

        // Bubble collapse under a stalled output
        do_reset();
        set_in(1'b1, 32'h20, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h21, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0); tick(); #1;
        check("bub_occ", 64'(occupancy_o), 64'(2));
        check("bub_od", 64'(out_data_o), 64'(32'h20));
        check("bub_in_ready", 64'(in_ready_o), 64'(1));
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0); tick(); #1;
        check("bub_od_next", 64'(out_data_o), 64'(32'h21));
        check("bub_ov_next", 64'(out_valid_o), 64'(1));

        // Kill of the middle stage
        do_reset();
        set_in(1'b1, 32'h30, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h31, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h32, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 3'b010); #1;
        check("kill_od0", 64'(out_data_o), 64'(32'h30));
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0); #1;
        check("kill_bubble_ov", 64'(out_valid_o), 64'(0));
        check("kill_occ", 64'(occupancy_o), 64'(1));
        tick(); #1;
        check("kill_ov1", 64'(out_valid_o), 64'(1));
        check("kill_od1", 64'(out_data_o), 64'(32'h32));

        // Flush of a full chain
        do_reset();
        set_in(1'b1, 32'h40, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h41, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h42, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h43, 1'b1, 1'b1, '0); #1;
        check("fl_ov", 64'(out_valid_o), 64'(0));
        check("fl_in_ready", 64'(in_ready_o), 64'(0));
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0); #1;
        check("fl_occ", 64'(occupancy_o), 64'(0));
        check("fl_ov_next", 64'(out_valid_o), 64'(0));

        // Asynchronous reset between edges
        do_reset();
        set_in(1'b1, 32'h50, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h51, 1'b0, 1'b0, '0); tick();
        set_in(1'b1, 32'h52, 1'b0, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0); tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0); #1;
        check("ar_pre_occ", 64'(occupancy_o), 64'(2));
        check("ar_pre_od", 64'(out_data_o), 64'(32'h51));
        #1;
        rst_i = 1'b1;
        #1;
        check("ar_ov", 64'(out_valid_o), 64'(0));
        check("ar_od", 64'(out_data_o), 64'(0));
        check("ar_occ", 64'(occupancy_o), 64'(0));
        check("ar_in_ready", 64'(in_ready_o), 64'(1));
        tick();
        rst_i = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            rst_i       = ($urandom_range(0, 249) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 39) == 0);
            kill_i      = ($urandom_range(0, 7) == 0) ? S'($urandom_range(1, 7)) : '0;
        end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, '0);
        rst_i = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
